// File: rtl/hamming_pkg.sv
// Shared types, code-length tables and helpers for the extended Hamming (SECDED)
// encoder and decoder models.
package hamming_pkg;

  typedef enum logic [1:0] {
    MODE_8    = 2'b00,
    MODE_16   = 2'b01,
    MODE_32   = 2'b10,
    MODE_RSVD = 2'b11
  } code_mode_t;

  localparam int CW_LEN   [3] = '{8, 16, 32};
  localparam int DATA_LEN [3] = '{4, 11, 26};
  localparam int CW_MAX       = CW_LEN[2];
  localparam int K_MAX        = DATA_LEN[2];

  function automatic logic is_pow2(input logic [4:0] pos);
    return (pos != 5'd0) && ((pos & (pos - 5'd1)) == 5'd0);
  endfunction

  // Codeword length for a mode; zero for the reserved code.
  function automatic logic [5:0] cw_len(input code_mode_t mode);
    logic [5:0] len;
    case (mode)
      MODE_8:  len = 6'(CW_LEN[0]);
      MODE_16: len = 6'(CW_LEN[1]);
      MODE_32: len = 6'(CW_LEN[2]);
      default: len = 6'd0;
    endcase
    return len;
  endfunction

  // Positions covered by parity bit 2^j.
  function automatic logic [CW_MAX-1:0] parity_mask(input int j);
    logic [CW_MAX-1:0] m;
    m = '0;
    for (int p = 1; p < CW_MAX; p++) begin
      m[5'(p)] = ((p >> j) & 1) == 1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational extended Hamming encoder: places data bits, computes the
// power-of-two parity bits and the overall parity at position 0.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [K_MAX-1:0]  data_in,
  input  code_mode_t        mode,
  output logic [CW_MAX-1:0] codeword
);

  logic [5:0]        len;
  logic [4:0]        di;
  logic [CW_MAX-1:0] cw;

  always_comb begin
    cw  = '0;
    di  = '0;
    len = cw_len(mode);
    // Data index advances on every non-power-of-two slot so it never depends on the mode.
    for (int p = 3; p < CW_MAX; p++) begin
      if (!is_pow2(5'(p))) begin
        if (6'(p) < len) cw[5'(p)] = data_in[di];
        di = di + 5'd1;
      end
    end
    for (int j = 0; j < 5; j++) begin
      if ((6'd1 << j) < len) cw[5'(1 << j)] = ^(cw & parity_mask(j));
    end
    cw[0] = ^cw;
    if (mode == MODE_RSVD) cw = '0;
    codeword = cw;
  end

endmodule

// File: rtl/hamming_serial_encoder.sv
// Accepts one payload per frame over valid/ready and shifts the SECDED codeword
// out LSB (position 0) first, one bit per clock.
module hamming_serial_encoder
  import hamming_pkg::*;
#(
  parameter int DATA_WIDTH = 32  // only 32 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [K_MAX-1:0] data_in,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state, state_d;
  logic [DATA_WIDTH-1:0]   sreg;
  logic [4:0]              cnt;
  logic [4:0]              last;
  logic [CW_MAX-1:0]       codeword;
  code_mode_t              mode_c;
  logic                    accept;
  logic                    load;

  assign mode_c = code_mode_t'(mode);

  hamming_parity_gen u_parity (
    .data_in  (data_in),
    .mode     (mode_c),
    .codeword (codeword)
  );

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (mode_c != MODE_RSVD)) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      last  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      err   <= accept && (mode_c == MODE_RSVD);
      if (load) begin
        sreg <= DATA_WIDTH'(codeword);
        cnt  <= '0;
        last <= 5'(cw_len(mode_c) - 6'd1);
      end else if (state == SHIFT) begin
        sreg <= sreg >> 1;
        // Return to zero after the last bit so the counter never runs past n-1.
        cnt  <= (cnt == last) ? 5'd0 : cnt + 5'd1;
      end
    end
  end

  assign out_valid = (state == SHIFT);
  assign data_out  = out_valid && sreg[0];
  assign out_sop   = out_valid && (cnt == 5'd0);
  assign out_eop   = out_valid && (cnt == last);

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// Directed and randomized bench for hamming_serial_encoder with an arithmetic
// reference model of the extended Hamming code.
module tb_hamming_serial_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] data_in;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic        data_out;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_serial_encoder #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_cw(input int m, input logic [25:0] d);
    int          n;
    int          par;
    logic [31:0] cw;
    logic [25:0] rem;
    n   = (m == 0) ? 8 : ((m == 1) ? 16 : 32);
    cw  = '0;
    rem = d;
    for (int p = 3; p < n; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw  = cw | (32'(rem[0]) << p);
        rem = rem >> 1;
      end
    end
    for (int j = 0; (1 << j) < n; j++) begin
      par = 0;
      for (int p = 1; p < n; p++) begin
        if (((p >> j) & 1) == 1) par = par ^ int'((cw >> p) & 32'd1);
      end
      cw = cw | (32'(par) << (1 << j));
    end
    cw = cw | 32'($countones(cw) % 2);
    return cw;
  endfunction

  task automatic send_frame(input logic [1:0] m, input logic [25:0] d,
                            input logic [31:0] exp, input bit keep);
    int n;
    n        = (m == 2'd0) ? 8 : ((m == 2'd1) ? 16 : 32);
    mode     = m;
    data_in  = d;
    in_valid = 1'b1;
    check("ready_before", 32'(in_ready), 32'd1);
    step();
    // Disturb the inputs mid-frame; the frame must be unaffected.
    in_valid = keep;
    mode     = m ^ 2'b10;
    data_in  = ~d;
    for (int i = 0; i < n; i++) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("data_bit", 32'(data_out), (exp >> i) & 32'd1);
      check("sop", 32'(out_sop), 32'(i == 0));
      check("eop", 32'(out_eop), 32'(i == n - 1));
      check("ready_busy", 32'(in_ready), 32'd0);
      step();
    end
    check("gap_ready", 32'(in_ready), 32'd1);
    check("gap_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [25:0] d;
    logic [1:0]  m;

    rst      = 1'b1;
    in_valid = 1'b0;
    mode     = 2'd0;
    data_in  = '0;
    step();
    step();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_sop", 32'(out_sop), 32'd0);
    check("rst_eop", 32'(out_eop), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Directed code vectors.
    send_frame(2'd0, 26'hB, 32'h000000AA, 1'b0);
    send_frame(2'd0, 26'hF, 32'h000000FF, 1'b0);
    send_frame(2'd0, 26'h0, 32'h00000000, 1'b0);
    send_frame(2'd1, 26'h1, 32'h0000000F, 1'b0);
    send_frame(2'd2, 26'h1, 32'h0000000F, 1'b0);

    // Reserved mode.
    mode     = 2'd3;
    r        = $urandom();
    data_in  = r[25:0];
    in_valid = 1'b1;
    check("rsvd_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("rsvd_err", 32'(err), 32'd1);
    check("rsvd_valid", 32'(out_valid), 32'd0);
    check("rsvd_ready_after", 32'(in_ready), 32'd1);
    step();
    check("rsvd_err_clear", 32'(err), 32'd0);
    check("rsvd_valid_after", 32'(out_valid), 32'd0);

    // Back-to-back frames with in_valid held high, alternating 8/32.
    for (int f = 0; f < 6; f++) begin
      m = (f % 2 == 1) ? 2'd2 : 2'd0;
      r = $urandom();
      d = r[25:0];
      send_frame(m, d, ref_cw(int'(m), d), 1'b1);
    end
    in_valid = 1'b0;
    step();

    // Reset in the middle of a 32-bit frame.
    r        = $urandom();
    d        = r[25:0];
    mode     = 2'd2;
    data_in  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abort_pre_valid", 32'(out_valid), 32'd1);
    check("abort_pre_bit", 32'(data_out), (ref_cw(2, d) >> 4) & 32'd1);
    rst = 1'b1;
    step();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_data", 32'(data_out), 32'd0);
    check("abort_sop", 32'(out_sop), 32'd0);
    check("abort_eop", 32'(out_eop), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready_after", 32'(in_ready), 32'd1);
    r = $urandom();
    d = r[25:0];
    send_frame(2'd2, d, ref_cw(2, d), 1'b0);

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      m = 2'($urandom_range(2, 0));
      r = $urandom();
      d = r[25:0];
      send_frame(m, d, ref_cw(int'(m), d), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_serial_encoder.md
Name: hamming_serial_encoder

Overview:
- Transmit-side stage directly upstream of the serial Hamming decoder.
- Accepts one parallel data word per frame through a valid/ready handshake.
- Encodes the word into an extended (SECDED) Hamming codeword of length 8, 16 or 32.
- Shifts the codeword out one bit per clock on a serial line that feeds the decoder's data_in.

Parameters:
- DATA_WIDTH, 32, maximum codeword length. 32 is the only legal value. Derived localparam K_MAX = 26 (data bits at length 32).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  26  parallel payload, LSB-aligned; bits at and above the mode's k are ignored.
- mode  in  2  code select: 00 = (8,4), 01 = (16,11), 10 = (32,26), 11 = reserved.
- in_valid  in  1  payload and mode are valid.
- in_ready  out  1  encoder can accept a word.
- data_out  out  1  serial codeword bit.
- out_valid  out  1  data_out carries a codeword bit.
- out_sop  out  1  first bit of frame (codeword position 0).
- out_eop  out  1  last bit of frame (position n-1).
- err  out  1  one-cycle pulse when a reserved mode is accepted.

Behaviour:
- Clocking and reset:
  - Single clock, clk. Reset is synchronous and active-high on rst.
  - While rst is high at a rising edge: state = IDLE, counter = 0, shift register = 0.
  - Output reset values: in_ready = 0 during the reset cycle and 1 from the first cycle after rst deasserts; data_out = 0; out_valid = 0; out_sop = 0; out_eop = 0; err = 0.
- Handshake:
  - Transfer occurs on a rising edge with in_valid && in_ready.
  - in_ready = 1 only in IDLE.
  - mode and data_in are sampled only at transfer. Later changes are ignored until the next transfer.
- Code construction, codeword positions 0..n-1:
  - Data bits d0, d1, ... fill the positions >= 3 that are not powers of two, in ascending order.
  - Parity bit at position 2^j = XOR of all positions p in 1..n-1 with bit j of p set, for j = 0..log2(n)-1.
  - Position 0 = XOR of positions 1..n-1 (even overall parity).
  - n/k pairs: 8/4, 16/11, 32/26.
- State machine IDLE -> SHIFT -> IDLE:
  - IDLE: on transfer with a legal mode, load the encoded codeword into a 32-bit shift register, load bit counter = 0, latch n, go to SHIFT.
  - IDLE, reserved mode (11): the transfer completes, err = 1 for exactly the next cycle, no frame is produced, state stays IDLE.
  - SHIFT: out_valid = 1, data_out = codeword[counter]. Bits go out in position order 0 first.
  - out_sop = 1 when counter == 0. out_eop = 1 when counter == n-1.
  - counter increments each cycle. At counter == n-1 the next state is IDLE.
- Timing:
  - Transfer at edge T: first bit valid in cycle T+1, last bit in cycle T+n.
  - IDLE with in_ready = 1 in cycle T+n+1.
  - Minimum frame period is n+1 cycles, with one idle gap between frames.
- Counter: 5 bits, no wrap beyond n-1. Compare against the latched n-1, not the live mode.
- Boundaries:
  - in_valid held high continuously: a new frame starts at every IDLE cycle.
  - rst high mid-frame: the frame is aborted at that edge, outputs drop to their reset values, and no partial resume occurs.
  - out_valid never deasserts inside a frame. There is no output backpressure; the decoder is always ready.

Decomposition:
- Package hamming_pkg:
  - typedef enum logic [1:0] code_mode_t {MODE_8, MODE_16, MODE_32, MODE_RSVD}.
  - Constants CW_LEN[] = {8, 16, 32} and DATA_LEN[] = {4, 11, 26}.
  - Function is_pow2(pos).
- Sub-module hamming_parity_gen: purely combinational.
  - Inputs: data_in and mode.
  - Output: 32-bit codeword; unused upper bits are 0.
  - Shared with the decoder's syndrome model.
- Top block: handshake, FSM, counter and shift register.

Test Plan:
- mode = 00, data_in = 4'b1011: codeword 8'hAA. Serial 0,1,0,1,0,1,0,1. out_sop in cycle T+1, out_eop in cycle T+8, in_ready back to 1 in cycle T+9.
- mode = 00, data_in = 4'hF -> 8'hFF. mode = 00, data_in = 0 -> eight 0 bits with out_valid high for exactly 8 cycles.
- mode = 01, data_in = 11'h001 -> 16'h000F (bits 1,1,1,1 then twelve 0s). mode = 10, data_in = 26'h0000001 -> 32'h0000000F over 32 cycles.
- mode = 11 with in_valid -> err high for 1 cycle, out_valid stays 0, in_ready stays 1.
- in_valid held high with alternating modes 00/10 -> frames of 8 and 32 bits separated by exactly one idle cycle. Changing mode mid-frame does not alter the frame length.
- rst asserted at the 5th bit of a 32-bit frame -> out_valid = 0 next cycle. A fresh frame after reset encodes its new data correctly from position 0.
